shift_reg_ser_to_par: RTL and testbench

- Serial-to-parallel shift register. It is the receive-side counterpart of the timer's parallel-to-serial display shifter.
- Collects a framed, MSB-first serial bit stream, one bit per enabled cycle, and presents each completed word in parallel with a one-cycle valid strobe.
- Used for loopback checking of the display serial link and for reading external serial peripherals into the stopwatch core.

---
 rtl/shift_reg_ser_to_par.sv | 100 ++++++++++
 tb/tb_shift_reg_ser_to_par.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shift_reg_ser_to_par.sv
// shift_reg_ser_to_par: framed MSB-first serial-to-parallel receiver; define SER_TO_PAR_PARITY_EN for an even-parity bit after each word.
module shift_reg_ser_to_par #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sync,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_TO_PAR_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, dout_q, dout_d, shifted;
  logic             valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
`ifdef SER_TO_PAR_PARITY_EN
  logic             par_q, par_d;
`endif
  assign shifted = {sr_q[WIDTH-2:0], data_in};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef SER_TO_PAR_PARITY_EN
    par_d   = par_q;
`endif
    if (ena && sync) begin
      state_d = SHIFT;
      cnt_d   = CW'(1);
      sr_d    = shifted;
      ferr_d  = (state_q == SHIFT);
`ifdef SER_TO_PAR_PARITY_EN
      par_d   = data_in;
`endif
    end else if (ena && state_q == SHIFT) begin
      cnt_d = cnt_q + CW'(1);
`ifdef SER_TO_PAR_PARITY_EN
      par_d = par_q ^ data_in;
      // the parity bit is checked but never enters the data word
      sr_d  = (cnt_q == CW'(WIDTH)) ? sr_q : shifted;
`else
      sr_d  = shifted;
`endif
      if (cnt_q == CW'(FRAME - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        dout_d  = sr_d;
`ifdef SER_TO_PAR_PARITY_EN
        perr_d  = par_d;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef SER_TO_PAR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`ifdef SER_TO_PAR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign data_out   = dout_q;
  assign valid      = valid_q;
  assign busy       = (state_q == SHIFT);
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
endmodule

// File: tb/tb_shift_reg_ser_to_par.sv
// tb_shift_reg_ser_to_par: directed frames with a scoreboard queue popped by a valid-driven monitor.
module tb_shift_reg_ser_to_par;
`ifdef SER_TO_PAR_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif
  logic clk = 1'b0, rst = 1'b0, ena = 1'b0, sync = 1'b0, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid, busy, frame_err, parity_err;
  int checks = 0, failures = 0;
  int cyc = 0, vcount = 0, exp_v = 0, ferr_seen = 0, exp_ferr = 0, busy_cyc = 0;
  int last_v = -1;
  bit gap_en = 1'b0;
  logic [8:0] q[$];

  shift_reg_ser_to_par #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sync(sync), .data_in(data_in),
    .data_out(data_out), .valid(valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cyc++;
      if (frame_err) ferr_seen++;
      if (parity_err && !valid) chk("parity_without_valid", parity_err, 0);
      if (valid) begin
        logic [8:0] e;
        vcount++;
        if (q.size() == 0) chk("unexpected_valid", data_out, 9'h1ff);
        else begin
          e = q.pop_front();
          chk("data_out", data_out, e[8:1]);
          chk("parity_err", parity_err, e[0]);
        end
        if (gap_en && last_v >= 0) chk("b2b_gap", cyc - last_v, FRAME);
        last_v = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1; sync = (i == 0); data_in = v[n-1-i];
      tick();
    end
    ena = 1'b0; sync = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input bit flip, input int pause_at);
    logic [8:0] v;
`ifdef SER_TO_PAR_PARITY_EN
    v = {w, ^w ^ flip};
    q.push_back({w, flip});
`else
    v = {1'b0, w};
    q.push_back({w, 1'b0});
`endif
    exp_v++;
    for (int i = 0; i < FRAME; i++) begin
      if (i == pause_at) begin
        ena = 1'b0; sync = 1'b1; data_in = 1'b1;
        repeat (5) tick();
        chk("pause_busy", busy, 1);
        chk("pause_no_valid", vcount, exp_v - 1);
      end
      ena = 1'b1; sync = (i == 0); data_in = v[FRAME-1-i];
      tick();
    end
    ena = 1'b0; sync = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    // idle bits without sync are ignored
    ena = 1'b1; data_in = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    chk("idle_ignore_busy", busy, 0);
    busy_cyc = 0;
    send_frame(8'hA5, 1'b0, -1);
    repeat (2) tick();
    chk("basic_busy_cycles", busy_cyc, FRAME - 1);
    chk("basic_vcount", vcount, 1);
    send_frame(8'hA5, 1'b0, 3);
    repeat (2) tick();
    chk("pause_vcount", vcount, 2);
    send_bits(9'h00f, 4);
    exp_ferr++;
    send_frame(8'h81, 1'b0, -1);
    repeat (2) tick();
    chk("midsync_ferr", ferr_seen, exp_ferr);
    chk("midsync_vcount", vcount, 3);
    send_bits(9'h1ff, FRAME - 1);
    exp_ferr++;
    send_frame(8'h5A, 1'b0, -1);
    repeat (2) tick();
    chk("lastbit_sync_ferr", ferr_seen, exp_ferr);
    chk("lastbit_sync_vcount", vcount, 4);
    send_bits(9'h01b, 5);
    rst = 1'b0;
    #2;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    send_frame(8'h3C, 1'b0, -1);
    repeat (2) tick();
    chk("post_rst_vcount", vcount, 5);
    gap_en = 1'b1; last_v = -1;
    repeat (4) send_frame(8'h81, 1'b0, -1);
    repeat (2) tick();
    gap_en = 1'b0;
    chk("b2b_ferr", ferr_seen, exp_ferr);
    chk("b2b_vcount", vcount, 9);
`ifdef SER_TO_PAR_PARITY_EN
    send_frame(8'hA5, 1'b0, -1);
    send_frame(8'hA5, 1'b1, -1);
    repeat (2) tick();
`endif
    chk("final_vcount", vcount, exp_v);
    chk("final_queue_empty", q.size(), 0);
    chk("final_ferr", ferr_seen, exp_ferr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
